// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory between instruction fetch and data access.
// Data has priority; a starvation counter periodically lets a waiting fetch through.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]            starve_q, starve_d;
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;   // 1 = data port, 0 = fetch port

    logic fetch_first;
    logic rd_push;
    logic resp_vld;
    logic resp_own;

    always_comb begin
        fetch_first = if_req && (!d_req || (starve_q == STARVE_MAX));
        if_gnt      = !rst && if_req && fetch_first;
        d_gnt       = !rst && d_req && !fetch_first;

        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en   = 1'b1;
            mem_addr = d_addr;
            if (d_we) begin
                mem_we    = d_be;
                mem_wdata = d_wdata;
            end
        end
    end

    // Only loads and fetches expect a response; a store with d_be=0 still carries d_we=1.
    assign rd_push = if_gnt || (d_gnt && !d_we);

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        tag_vld_d = (tag_vld_q << 1) | RD_LATENCY'(rd_push);
        tag_own_d = (tag_own_q << 1) | RD_LATENCY'(d_gnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            starve_q  <= starve_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
        end
    end

    // Gating with rst keeps a response that reaches the last stage during reset from leaking out.
    assign resp_vld = !rst && tag_vld_q[RD_LATENCY-1];
    assign resp_own = tag_own_q[RD_LATENCY-1];

    always_comb begin
        if_rvalid = resp_vld && !resp_own;
        d_rvalid  = resp_vld && resp_own;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 2) driven by shared requests,
// each backed by its own behavioural memory; expectations come from a reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned SL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;

    logic          a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en;
    logic [31:0]   a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic [3:0]    a_mem_we;
    logic [AW-1:0] a_mem_addr;

    logic          b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en;
    logic [31:0]   b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic [3:0]    b_mem_we;
    logic [AW-1:0] b_mem_addr;

    mem_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(1), .STARVE_LIMIT(SL)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .STARVE_LIMIT(SL)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    logic [116:0] a_all, b_all;
    assign a_all = {a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_if_rdata, a_d_rdata,
                    a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata};
    assign b_all = {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata,
                    b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata};

    function automatic logic [31:0] init_word(int unsigned i);
        return (i == 16) ? 32'h0000_0013 : (32'hA500_0000 ^ (32'(i) * 32'h0001_0203));
    endfunction

    // Behavioural memories: requests latched mid-cycle, acted on at the next rising edge.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    bit          mem_ready = 1'b0;
    logic        cap_a_en = 1'b0, cap_b_en = 1'b0;
    logic [3:0]  cap_a_we = '0, cap_b_we = '0;
    logic [5:0]  cap_a_addr = '0, cap_b_addr = '0;
    logic [31:0] cap_a_wd = '0, cap_b_wd = '0;
    logic [31:0] ra0 = '0, rb0 = '0, rb1 = '0;

    always @(negedge clk) begin
        cap_a_en = a_mem_en; cap_a_we = a_mem_we; cap_a_addr = a_mem_addr[5:0]; cap_a_wd = a_mem_wdata;
        cap_b_en = b_mem_en; cap_b_we = b_mem_we; cap_b_addr = b_mem_addr[5:0]; cap_b_wd = b_mem_wdata;
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] = init_word(i);
                mem_b[i] = init_word(i);
            end
            mem_ready = 1'b1;
        end
        ra0 <= mem_a[cap_a_addr];
        rb0 <= mem_b[cap_b_addr];
        rb1 <= rb0;
        if (cap_a_en)
            for (int b = 0; b < 4; b++)
                if (cap_a_we[b]) mem_a[cap_a_addr][8*b +: 8] = cap_a_wd[8*b +: 8];
        if (cap_b_en)
            for (int b = 0; b < 4; b++)
                if (cap_b_we[b]) mem_b[cap_b_addr][8*b +: 8] = cap_b_wd[8*b +: 8];
    end

    assign a_mem_rdata = ra0;
    assign b_mem_rdata = rb1;

    // Reference model state
    logic [31:0] ref_mem [0:63];
    logic        hv    [0:15];
    logic        hown  [0:15];
    logic [31:0] hdata [0:15];
    int unsigned cyc = 16;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 12'h003;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 12'h007; d_wdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_all !== '0) $display("FAIL reset_outputs_lat1: got %h required 0", a_all);
            else n_pass++;
            n_checks++;
            if (b_all !== '0) $display("FAIL reset_outputs_lat2: got %h required 0", b_all);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
        if_req = 1'b0; d_we = 1'b0; d_addr = 12'h002;
        @(negedge clk);
        n_checks++;
        if ({b_d_gnt, b_mem_en, b_mem_we, b_mem_addr} !== {1'b1, 1'b1, 4'h0, 12'h002})
            $display("FAIL first_grant_after_reset: got %b_%b_%h_%h required 1_1_0_002",
                     b_d_gnt, b_mem_en, b_mem_we, b_mem_addr);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_fetch_read();
        idle_inputs();
        if_req = 1'b1; if_addr = 12'h010;
        @(negedge clk);
        n_checks++;
        if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {1'b1, 1'b0, 1'b1, 4'h0, 12'h010})
            $display("FAIL fetch_grant: got %b%b%b_%h_%h required 101_0_010",
                     a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr);
        else n_pass++;
        tick();
        if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_if_rvalid, a_if_rdata, a_d_rvalid} !== {1'b1, 32'h0000_0013, 1'b0})
            $display("FAIL fetch_resp_lat1: got v=%b d=%h dv=%b required v=1 d=00000013 dv=0",
                     a_if_rvalid, a_if_rdata, a_d_rvalid);
        else n_pass++;
        n_checks++;
        if ({b_if_rvalid, b_d_rvalid} !== 2'b00)
            $display("FAIL fetch_early_lat2: got %b%b required 00", b_if_rvalid, b_d_rvalid);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({a_if_rvalid, a_d_rvalid} !== 2'b00)
            $display("FAIL fetch_pulse_lat1: got %b%b required 00", a_if_rvalid, a_d_rvalid);
        else n_pass++;
        n_checks++;
        if ({b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata} !== {1'b1, 1'b0, 32'h0000_0013, 32'h0})
            $display("FAIL fetch_resp_lat2: got %b%b %h %h required 10 00000013 00000000",
                     b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_store();
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 12'h020; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !==
            {1'b0, 1'b1, 1'b1, 4'b0011, 12'h020, 32'hDEAD_BEEF})
            $display("FAIL store_drive: got %b%b%b_%b_%h_%h required 011_0011_020_deadbeef",
                     a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
        else n_pass++;
        tick();
        idle_inputs();
        ref_mem[32][15:0] = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({a_if_rvalid, a_d_rvalid, b_if_rvalid, b_d_rvalid} !== 4'b0000)
                $display("FAIL store_no_rvalid: got %b%b%b%b required 0000",
                         a_if_rvalid, a_d_rvalid, b_if_rvalid, b_d_rvalid);
            else n_pass++;
            tick();
        end
        d_req = 1'b1; d_addr = 12'h020;
        @(negedge clk);
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({a_d_rvalid, a_d_rdata} !== {1'b1, ref_mem[32]})
            $display("FAIL store_readback: got %b %h required 1 %h", a_d_rvalid, a_d_rdata, ref_mem[32]);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_store_zero_be();
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000; d_addr = 12'h021; d_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        n_checks++;
        if ({b_d_gnt, b_mem_en, b_mem_we, b_mem_addr} !== {1'b1, 1'b1, 4'b0000, 12'h021})
            $display("FAIL store_be0_drive: got %b%b_%b_%h required 11_0000_021",
                     b_d_gnt, b_mem_en, b_mem_we, b_mem_addr);
        else n_pass++;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({a_if_rvalid, a_d_rvalid, b_if_rvalid, b_d_rvalid} !== 4'b0000)
                $display("FAIL store_be0_no_rvalid: got %b%b%b%b required 0000",
                         a_if_rvalid, a_d_rvalid, b_if_rvalid, b_d_rvalid);
            else n_pass++;
            tick();
        end
        d_req = 1'b1; d_addr = 12'h021;
        @(negedge clk);
        tick();
        idle_inputs();
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if ({b_d_rvalid, b_d_rdata} !== {1'b1, ref_mem[33]})
            $display("FAIL store_be0_unchanged: got %b %h required 1 %h", b_d_rvalid, b_d_rdata, ref_mem[33]);
        else n_pass++;
        tick();
    endtask

    task automatic test_starvation();
        logic [1:0] exp_g;
        idle_inputs();
        tick();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if_addr = AW'(k);
            d_addr  = AW'(k + 32);
            exp_g = ((k % 5) == 4) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_checks++;
            if ({b_if_gnt, b_d_gnt} !== exp_g)
                $display("FAIL starve_seq_%0d: got %b required %b", k, {b_if_gnt, b_d_gnt}, exp_g);
            else n_pass++;
            n_checks++;
            if ({a_if_gnt, a_d_gnt} !== exp_g)
                $display("FAIL starve_seq_lat1_%0d: got %b required %b", k, {a_if_gnt, a_d_gnt}, exp_g);
            else n_pass++;
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_g;
        logic [65:0] exp_r;
        int          src;
        for (int k = 0; k < 9; k++) begin
            idle_inputs();
            if (k < 6) begin
                if ((k % 2) == 0) begin d_req = 1'b1; d_addr = 12'h004; end
                else begin if_req = 1'b1; if_addr = 12'h008; end
            end
            exp_g = (k >= 6) ? 2'b00 : (((k % 2) == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            n_checks++;
            if ({b_if_gnt, b_d_gnt} !== exp_g)
                $display("FAIL b2b_grant_%0d: got %b required %b", k, {b_if_gnt, b_d_gnt}, exp_g);
            else n_pass++;
            for (int lat = 1; lat <= 2; lat++) begin
                src = k - lat;
                exp_r = '0;
                if (src >= 0 && src < 6) begin
                    if ((src % 2) == 0) exp_r = {1'b0, 1'b1, 32'h0, ref_mem[4]};
                    else                exp_r = {1'b1, 1'b0, ref_mem[8], 32'h0};
                end
                if (lat == 1) begin
                    n_checks++;
                    if ({a_if_rvalid, a_d_rvalid, a_if_rdata, a_d_rdata} !== exp_r)
                        $display("FAIL b2b_resp_lat1_%0d: got %h required %h", k,
                                 {a_if_rvalid, a_d_rvalid, a_if_rdata, a_d_rdata}, exp_r);
                    else n_pass++;
                end else begin
                    n_checks++;
                    if ({b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata} !== exp_r)
                        $display("FAIL b2b_resp_lat2_%0d: got %h required %h", k,
                                 {b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata}, exp_r);
                    else n_pass++;
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_inflight();
        logic [1:0] exp_g;
        idle_inputs();
        tick();
        if_req = 1'b1; if_addr = 12'h001;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h005;
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if (b_d_gnt !== 1'b1) $display("FAIL inflight_load_grant: got %b required 1", b_d_gnt);
        else n_pass++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b_all !== '0) $display("FAIL inflight_reset_lat2: got %h required 0", b_all);
        else n_pass++;
        n_checks++;
        if (a_all !== '0) $display("FAIL inflight_reset_lat1: got %h required 0", a_all);
        else n_pass++;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            exp_g = (j == 4) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_checks++;
            if ({b_if_gnt, b_d_gnt} !== exp_g)
                $display("FAIL post_reset_counter_%0d: got %b required %b", j, {b_if_gnt, b_d_gnt}, exp_g);
            else n_pass++;
            if (j < 2) begin
                n_checks++;
                if ({b_if_rvalid, b_d_rvalid} !== 2'b00)
                    $display("FAIL inflight_dropped_%0d: got %b%b required 00", j, b_if_rvalid, b_d_rvalid);
                else n_pass++;
            end
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic          if_pend, d_pend, ff, e_ifg, e_dg, e_rst, e_v;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wd;
        logic [50:0]   exp_m;
        logic [65:0]   exp_r, got_r;
        int unsigned   waited, slot, s;
        if_pend = 1'b0; d_pend = 1'b0; waited = 0;
        for (int i = 0; i < 16; i++) hv[i] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            e_rst = (i == 0) || ($urandom_range(0, 39) == 0);
            rst = e_rst;
            if (!if_pend) if_req = ($urandom_range(0, 3) != 0);
            if (!d_pend)  d_req  = ($urandom_range(0, 9) != 0);
            if_addr = AW'($urandom_range(0, 31));
            d_addr  = AW'($urandom_range(0, 31));
            d_we    = ($urandom_range(0, 2) == 0);
            d_be    = 4'($urandom);
            d_wdata = $urandom;

            ff     = if_req && (!d_req || waited == SL);
            e_ifg  = !e_rst && if_req && ff;
            e_dg   = !e_rst && d_req && !ff;
            e_we   = (e_dg && d_we) ? d_be : 4'h0;
            e_wd   = (e_dg && d_we) ? d_wdata : 32'h0;
            e_addr = e_ifg ? if_addr : (e_dg ? d_addr : '0);
            exp_m  = {e_ifg, e_dg, e_ifg || e_dg, e_we, e_addr, e_wd};
            slot   = cyc % 16;
            hv[slot] = 1'b0;

            @(negedge clk);
            n_checks++;
            if ({b_if_gnt, b_d_gnt, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata} !== exp_m)
                $display("FAIL rnd_mem_lat2 cyc %0d: got %h required %h", cyc,
                         {b_if_gnt, b_d_gnt, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata}, exp_m);
            else n_pass++;
            n_checks++;
            if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== exp_m)
                $display("FAIL rnd_mem_lat1 cyc %0d: got %h required %h", cyc,
                         {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}, exp_m);
            else n_pass++;

            for (int lat = 1; lat <= 2; lat++) begin
                s   = (cyc - lat) % 16;
                e_v = !e_rst && hv[s];
                exp_r = {e_v && !hown[s], e_v && hown[s],
                         (e_v && !hown[s]) ? hdata[s] : 32'h0,
                         (e_v &&  hown[s]) ? hdata[s] : 32'h0};
                got_r = (lat == 1) ? {a_if_rvalid, a_d_rvalid, a_if_rdata, a_d_rdata}
                                   : {b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata};
                n_checks++;
                if (got_r !== exp_r)
                    $display("FAIL rnd_resp_lat%0d cyc %0d: got %h required %h", lat, cyc, got_r, exp_r);
                else n_pass++;
            end

            if (e_rst)
                for (int j = 1; j <= 4; j++) hv[(cyc - j) % 16] = 1'b0;
            if (e_ifg || (e_dg && !d_we)) begin
                hv[slot]    = 1'b1;
                hown[slot]  = e_dg;
                hdata[slot] = ref_mem[e_addr[5:0]];
            end
            if (e_dg && d_we)
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ref_mem[d_addr[5:0]][8*b +: 8] = d_wdata[8*b +: 8];
            if (e_rst || !if_req || e_ifg) waited = 0;
            else if (e_dg) waited++;
            if_pend = if_req && !e_ifg;
            d_pend  = d_req && !e_dg;
            cyc++;
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_fetch_read();
        test_store();
        test_store_zero_be();
        test_starvation();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
